// File: rtl/noc_axi_wr_traffic_gen.sv
// AXI4 write traffic generator: N strided INCR bursts with a bounded outstanding count,
// a deterministic W data pattern, and in-order B response checking with a sticky error.
module noc_axi_wr_traffic_gen #(
    parameter int unsigned AddrWidth      = 40,
    parameter int unsigned DataWidth      = 512,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned CntWidth       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [CntWidth-1:0]    num_txn_i,
    input  logic [7:0]             burst_len_i,
    input  logic [AddrWidth-1:0]   addr_base_i,
    input  logic [AddrWidth-1:0]   addr_stride_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [CntWidth-1:0]    txn_sent_o,
    output logic [CntWidth-1:0]    rsp_cnt_o,
    output logic                   awvalid_o,
    input  logic                   awready_i,
    output logic [AddrWidth-1:0]   awaddr_o,
    output logic [IdWidth-1:0]     awid_o,
    output logic [7:0]             awlen_o,
    output logic [2:0]             awsize_o,
    output logic [1:0]             awburst_o,
    output logic                   wvalid_o,
    input  logic                   wready_i,
    output logic [DataWidth-1:0]   wdata_o,
    output logic [DataWidth/8-1:0] wstrb_o,
    output logic                   wlast_o,
    input  logic                   bvalid_i,
    output logic                   bready_o,
    input  logic [IdWidth-1:0]     bid_i,
    input  logic [1:0]             bresp_i
);

    localparam int unsigned NumLanes = DataWidth / 32;
    localparam logic [CntWidth-1:0] MaxOut = CntWidth'(MaxOutstanding);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
    localparam logic [CntWidth-1:0] CntMax = '1;
    localparam logic [IdWidth-1:0]  IdOne  = IdWidth'(1);
    localparam logic [2:0]          AwSize = 3'($clog2(DataWidth / 8));

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CntWidth-1:0]    num_txn_q;
    logic [7:0]             burst_len_q;
    logic [AddrWidth-1:0]   stride_q;
    logic [AddrWidth-1:0]   awaddr_q;
    logic [IdWidth-1:0]     awid_q;
    logic [IdWidth-1:0]     bid_exp_q;
    logic [CntWidth-1:0]    aw_cnt_q, rsp_cnt_q, outst_q, pending_q;
    logic [15:0]            w_txn_q;
    logic [7:0]             beat_q;
    logic                   err_q, bready_q;

    logic start_ok, aw_hs, w_hs, wlast_hs, b_hs, b_acc;
    logic [CntWidth-1:0] aw_cnt_inc;

    assign start_ok   = start_i && (state_q == StIdle || state_q == StDone);
    assign awvalid_o  = (state_q == StRun) && (outst_q < MaxOut);
    assign aw_hs      = awvalid_o && awready_i;
    assign wvalid_o   = (pending_q != '0);
    assign wlast_o    = wvalid_o && (beat_q == burst_len_q);
    assign w_hs       = wvalid_o && wready_i;
    assign wlast_hs   = w_hs && wlast_o;
    assign b_hs       = bvalid_i && bready_o;
    // A response with nothing outstanding is flagged but not counted.
    assign b_acc      = b_hs && (outst_q != '0);
    assign aw_cnt_inc = aw_cnt_q + CntOne;

    assign busy_o     = (state_q == StRun) || (state_q == StDrain);
    assign done_o     = (state_q == StDone);
    assign err_o      = err_q;
    assign txn_sent_o = aw_cnt_q;
    assign rsp_cnt_o  = rsp_cnt_q;
    assign awaddr_o   = awaddr_q;
    assign awid_o     = awid_q;
    assign awlen_o    = burst_len_q;
    assign awsize_o   = AwSize;
    assign awburst_o  = 2'b01;
    assign wstrb_o    = '1;
    assign bready_o   = bready_q;

    always_comb begin
        wdata_o = '0;
        for (int k = 0; k < NumLanes; k++) begin
            wdata_o[k*32 +: 32] = {w_txn_q, beat_q, 8'(k)};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (start_i) state_d = (num_txn_i == '0) ? StDone : StRun;
            end
            StRun: begin
                if (aw_hs && aw_cnt_inc == num_txn_q) state_d = StDrain;
            end
            StDrain: begin
                if (pending_q == '0 && rsp_cnt_q == num_txn_q) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            num_txn_q   <= '0;
            burst_len_q <= '0;
            stride_q    <= '0;
            awaddr_q    <= '0;
            awid_q      <= '0;
            bid_exp_q   <= '0;
            aw_cnt_q    <= '0;
            rsp_cnt_q   <= '0;
            outst_q     <= '0;
            pending_q   <= '0;
            w_txn_q     <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            bready_q <= 1'b1;
            if (start_ok) begin
                num_txn_q   <= num_txn_i;
                burst_len_q <= burst_len_i;
                stride_q    <= addr_stride_i;
                awaddr_q    <= addr_base_i;
                awid_q      <= '0;
                bid_exp_q   <= '0;
                aw_cnt_q    <= '0;
                rsp_cnt_q   <= '0;
                outst_q     <= '0;
                pending_q   <= '0;
                w_txn_q     <= '0;
                beat_q      <= '0;
                err_q       <= 1'b0;
            end else begin
                if (aw_hs) begin
                    awaddr_q <= awaddr_q + stride_q;
                    awid_q   <= awid_q + IdOne;
                    if (aw_cnt_q != CntMax) aw_cnt_q <= aw_cnt_inc;
                end
                if (aw_hs && !b_acc)      outst_q <= outst_q + CntOne;
                else if (!aw_hs && b_acc) outst_q <= outst_q - CntOne;
                if (aw_hs && !wlast_hs)      pending_q <= pending_q + CntOne;
                else if (!aw_hs && wlast_hs) pending_q <= pending_q - CntOne;
                if (w_hs) begin
                    if (wlast_o) begin
                        beat_q  <= '0;
                        w_txn_q <= w_txn_q + 16'd1;
                    end else begin
                        beat_q  <= beat_q + 8'd1;
                    end
                end
                if (b_acc) begin
                    bid_exp_q <= bid_exp_q + IdOne;
                    if (rsp_cnt_q != CntMax) rsp_cnt_q <= rsp_cnt_q + CntOne;
                    if (bresp_i != 2'b00 || bid_i != bid_exp_q) err_q <= 1'b1;
                end else if (b_hs) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_axi_wr_traffic_gen.sv
// Directed bench for noc_axi_wr_traffic_gen: AW/W scoreboards filled at start,
// an in-order B responder with credit and error injection, and stall stability checks.
module tb_noc_axi_wr_traffic_gen;
    localparam int unsigned AW = 40;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 4;
    localparam int unsigned MO = 2;
    localparam int unsigned CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [CW-1:0] num_txn_i = '0;
    logic [7:0]    burst_len_i = '0;
    logic [AW-1:0] addr_base_i = '0;
    logic [AW-1:0] addr_stride_i = '0;
    logic          busy_o, done_o, err_o;
    logic [CW-1:0] txn_sent_o, rsp_cnt_o;
    logic          awvalid_o;
    logic          awready_i = 1'b1;
    logic [AW-1:0] awaddr_o;
    logic [IW-1:0] awid_o;
    logic [7:0]    awlen_o;
    logic [2:0]    awsize_o;
    logic [1:0]    awburst_o;
    logic          wvalid_o;
    logic          wready_i = 1'b1;
    logic [DW-1:0] wdata_o;
    logic [DW/8-1:0] wstrb_o;
    logic          wlast_o;
    logic          bvalid_i = 1'b0;
    logic          bready_o;
    logic [IW-1:0] bid_i = '0;
    logic [1:0]    bresp_i = 2'b00;

    always #5 clk_i = ~clk_i;

    noc_axi_wr_traffic_gen #(
        .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxOutstanding(MO), .CntWidth(CW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .num_txn_i(num_txn_i),
        .burst_len_i(burst_len_i), .addr_base_i(addr_base_i), .addr_stride_i(addr_stride_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .txn_sent_o(txn_sent_o),
        .rsp_cnt_o(rsp_cnt_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .awaddr_o(awaddr_o), .awid_o(awid_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
        .awburst_o(awburst_o), .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o),
        .wstrb_o(wstrb_o), .wlast_o(wlast_o), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .bid_i(bid_i), .bresp_i(bresp_i)
    );

    int checks = 0;
    int failures = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [IW-1:0] exp_id_q[$];
    logic [7:0]    exp_len_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic          exp_last_q[$];
    logic [IW-1:0] bq[$];

    int b_credits = 1000;
    int b_idx = 0;
    int err_txn = -1;
    bit rand_mode = 1'b0;
    bit b_fire_flag = 1'b0;
    int aw_seen = 0, w_beats = 0, w_lasts = 0, b_fires = 0;

    logic          prev_aw_stall = 1'b0, prev_w_stall = 1'b0;
    logic [AW-1:0] prev_awaddr;
    logic [IW-1:0] prev_awid;
    logic [7:0]    prev_awlen;
    logic [DW-1:0] prev_wdata;
    logic          prev_wlast;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input int t, input int b);
        logic [15:0] ti;
        logic [7:0]  bi;
        logic [DW-1:0] d;
        ti = 16'(t);
        bi = 8'(b);
        d = '0;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = {ti, bi, 8'(k)};
        return d;
    endfunction

    task automatic run_start(input int n, input int len, input logic [AW-1:0] base,
                             input logic [AW-1:0] stride);
        logic [AW-1:0] a;
        a = base;
        @(posedge clk_i); #1;
        start_i = 1'b1;
        num_txn_i = CW'(n);
        burst_len_i = 8'(len);
        addr_base_i = base;
        addr_stride_i = stride;
        aw_seen = 0; w_beats = 0; w_lasts = 0; b_fires = 0; b_idx = 0;
        for (int t = 0; t < n; t++) begin
            exp_addr_q.push_back(a);
            exp_id_q.push_back(IW'(t));
            exp_len_q.push_back(8'(len));
            for (int b = 0; b <= len; b++) begin
                exp_data_q.push_back(exp_data(t, b));
                exp_last_q.push_back(b == len);
            end
            a = a + stride;
        end
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!done_o && n < budget);
        chk("done_reached", 64'(done_o), 64'(1));
        chk("aw_queue_empty", 64'(exp_addr_q.size()), 64'(0));
        chk("w_queue_empty", 64'(exp_data_q.size()), 64'(0));
    endtask

    // Observe handshakes on the falling edge; they complete on the next rising edge.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_aw_stall = 1'b0;
            prev_w_stall = 1'b0;
            b_fire_flag = 1'b0;
        end else begin
            if (prev_aw_stall) begin
                chk("aw_hold_valid", 64'(awvalid_o), 64'(1));
                chk("aw_hold_addr", 64'(awaddr_o), 64'(prev_awaddr));
                chk("aw_hold_id", 64'(awid_o), 64'(prev_awid));
                chk("aw_hold_len", 64'(awlen_o), 64'(prev_awlen));
            end
            if (prev_w_stall) begin
                chk("w_hold_valid", 64'(wvalid_o), 64'(1));
                chk("w_hold_data", 64'(wdata_o), 64'(prev_wdata));
                chk("w_hold_last", 64'(wlast_o), 64'(prev_wlast));
            end
            prev_aw_stall = awvalid_o && !awready_i;
            prev_awaddr = awaddr_o;
            prev_awid = awid_o;
            prev_awlen = awlen_o;
            prev_w_stall = wvalid_o && !wready_i;
            prev_wdata = wdata_o;
            prev_wlast = wlast_o;
            if (wvalid_o) chk("w_not_before_aw", 64'(aw_seen > w_lasts), 64'(1));
            if (awvalid_o && awready_i) begin
                if (exp_addr_q.size() == 0) begin
                    chk("aw_extra", 64'(exp_addr_q.size()), 64'(1));
                end else begin
                    chk("awaddr", 64'(awaddr_o), 64'(exp_addr_q.pop_front()));
                    chk("awid", 64'(awid_o), 64'(exp_id_q.pop_front()));
                    chk("awlen", 64'(awlen_o), 64'(exp_len_q.pop_front()));
                    chk("awsize", 64'(awsize_o), 64'(3));
                    chk("awburst", 64'(awburst_o), 64'(1));
                end
                bq.push_back(awid_o);
                aw_seen++;
            end
            if (wvalid_o && wready_i) begin
                if (exp_data_q.size() == 0) begin
                    chk("w_extra", 64'(exp_data_q.size()), 64'(1));
                end else begin
                    chk("wdata", 64'(wdata_o), 64'(exp_data_q.pop_front()));
                    chk("wlast", 64'(wlast_o), 64'(exp_last_q.pop_front()));
                    chk("wstrb", 64'(wstrb_o), 64'(8'hff));
                end
                w_beats++;
                if (wlast_o) w_lasts++;
            end
            if (bvalid_i && bready_o) begin
                b_fire_flag = 1'b1;
                b_fires++;
            end
        end
    end

    // In-order B responder with credits, error injection and optional random ready stalls.
    always @(posedge clk_i) begin
        #1;
        if (!rst_ni) begin
            bvalid_i = 1'b0;
        end else begin
            if (b_fire_flag) begin
                bvalid_i = 1'b0;
                b_fire_flag = 1'b0;
            end
            if (!bvalid_i && b_credits > 0 && bq.size() > 0) begin
                bvalid_i = 1'b1;
                bid_i = bq.pop_front();
                bresp_i = (b_idx == err_txn) ? 2'b10 : 2'b00;
                b_idx++;
                b_credits--;
            end
            if (rand_mode) begin
                awready_i = 1'($urandom_range(0, 1));
                wready_i = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        int n;
        logic found;

        // Reset values while rst_ni is low.
        #2;
        chk("rst_awvalid", 64'(awvalid_o), 64'(0));
        chk("rst_wvalid", 64'(wvalid_o), 64'(0));
        chk("rst_wlast", 64'(wlast_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));
        chk("rst_txn_sent", 64'(txn_sent_o), 64'(0));
        chk("rst_rsp_cnt", 64'(rsp_cnt_o), 64'(0));
        chk("rst_bready", 64'(bready_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("bready_after_rst", 64'(bready_o), 64'(1));
        chk("idle_done", 64'(done_o), 64'(0));

        // Zero-length run: DONE one cycle after start, no channel activity.
        run_start(0, 0, 40'h0, 40'h0);
        @(negedge clk_i);
        chk("zero_done", 64'(done_o), 64'(1));
        chk("zero_busy", 64'(busy_o), 64'(0));
        chk("zero_awvalid", 64'(awvalid_o), 64'(0));
        chk("zero_wvalid", 64'(wvalid_o), 64'(0));
        repeat (3) @(negedge clk_i);
        chk("zero_no_aw", 64'(aw_seen), 64'(0));

        // Basic run, all ready.
        run_start(4, 3, 40'h1000, 40'h100);
        wait_done(200);
        chk("basic_err", 64'(err_o), 64'(0));
        chk("basic_txn_sent", 64'(txn_sent_o), 64'(4));
        chk("basic_rsp_cnt", 64'(rsp_cnt_o), 64'(4));
        chk("basic_w_beats", 64'(w_beats), 64'(16));
        chk("basic_w_lasts", 64'(w_lasts), 64'(4));
        chk("basic_b_fires", 64'(b_fires), 64'(4));

        // Outstanding limit with B withheld.
        b_credits = 0;
        run_start(5, 0, 40'h4000, 40'h40);
        repeat (10) @(negedge clk_i);
        chk("maxout_aw_count", 64'(aw_seen), 64'(MO));
        chk("maxout_awvalid_low", 64'(awvalid_o), 64'(0));
        chk("maxout_busy", 64'(busy_o), 64'(1));
        b_credits = 1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(bvalid_i && bready_o) && n < 10);
        chk("maxout_b_seen", 64'(bvalid_i && bready_o), 64'(1));
        chk("maxout_same_cycle", 64'(awvalid_o), 64'(0));
        @(negedge clk_i);
        chk("maxout_next_cycle", 64'(awvalid_o), 64'(1));
        @(negedge clk_i);
        chk("maxout_one_more", 64'(aw_seen), 64'(MO + 1));
        chk("maxout_full_again", 64'(awvalid_o), 64'(0));
        b_credits = 1000;
        wait_done(200);
        chk("maxout_txn_sent", 64'(txn_sent_o), 64'(5));
        chk("maxout_rsp_cnt", 64'(rsp_cnt_o), 64'(5));

        // AW held off: W must not lead.
        awready_i = 1'b0;
        run_start(2, 1, 40'h6000, 40'h80);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("w_waits_for_aw", 64'(wvalid_o), 64'(0));
        end
        chk("aw_pending_valid", 64'(awvalid_o), 64'(1));
        awready_i = 1'b1;
        wait_done(200);

        // Random ready stalls.
        rand_mode = 1'b1;
        run_start(6, 2, 40'h8000, 40'h200);
        wait_done(2000);
        rand_mode = 1'b0;
        awready_i = 1'b1;
        wready_i = 1'b1;
        chk("rand_err", 64'(err_o), 64'(0));
        chk("rand_txn_sent", 64'(txn_sent_o), 64'(6));

        // SLVERR on the third response.
        err_txn = 2;
        run_start(4, 1, 40'hA000, 40'h100);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (rsp_cnt_o != 2 && n < 200);
        chk("err_before_bad_b", 64'(err_o), 64'(0));
        wait_done(200);
        chk("err_sticky_done", 64'(err_o), 64'(1));
        err_txn = -1;
        run_start(1, 0, 40'hB000, 40'h0);
        @(negedge clk_i);
        chk("err_cleared_on_start", 64'(err_o), 64'(0));
        chk("restart_busy", 64'(busy_o), 64'(1));
        wait_done(100);
        chk("restart_err", 64'(err_o), 64'(0));

        // Address wrap; the scoreboard expects 0x80 for the second burst.
        run_start(2, 0, 40'hFF_FFFF_FF80, 40'h100);
        wait_done(100);
        chk("wrap_txn_sent", 64'(txn_sent_o), 64'(2));

        // Asynchronous reset in the middle of the first burst.
        run_start(4, 3, 40'h1000, 40'h100);
        n = 0;
        found = 1'b0;
        do begin
            @(negedge clk_i);
            n++;
            found = wvalid_o && wready_i && (wdata_o[15:8] == 8'd2);
        end while (!found && n < 50);
        chk("midrst_beat2_seen", 64'(found), 64'(1));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_awvalid", 64'(awvalid_o), 64'(0));
        chk("midrst_wvalid", 64'(wvalid_o), 64'(0));
        chk("midrst_wlast", 64'(wlast_o), 64'(0));
        chk("midrst_busy", 64'(busy_o), 64'(0));
        chk("midrst_done", 64'(done_o), 64'(0));
        chk("midrst_err", 64'(err_o), 64'(0));
        chk("midrst_txn_sent", 64'(txn_sent_o), 64'(0));
        chk("midrst_rsp_cnt", 64'(rsp_cnt_o), 64'(0));
        chk("midrst_bready", 64'(bready_o), 64'(0));
        exp_addr_q.delete();
        exp_id_q.delete();
        exp_len_q.delete();
        exp_data_q.delete();
        exp_last_q.delete();
        bq.delete();
        bvalid_i = 1'b0;
        @(negedge clk_i);
        #3;
        rst_ni = 1'b1;
        run_start(3, 1, 40'h2000, 40'h40);
        @(negedge clk_i);
        chk("post_rst_cnt_zero", 64'(txn_sent_o), 64'(0));
        wait_done(200);
        chk("post_rst_txn_sent", 64'(txn_sent_o), 64'(3));
        chk("post_rst_rsp_cnt", 64'(rsp_cnt_o), 64'(3));
        chk("post_rst_err", 64'(err_o), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
